// File: rtl/smm0.sv
`default_nettype none
// ============================================================================
// Module      : smm0
// Description : 2x2 signed matrix multiply using Strassen's seven products,
//               with a matrix-vector mode (sel=1) that uses column 0 of B.
// Revision    : 1.0 - initial release
// ============================================================================
module smm0 #(
    parameter int DATAWIDTH = 32,
    parameter int BLOCKSIZE = DATAWIDTH,
    parameter int BUSWIDTH  = BLOCKSIZE * 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BUSWIDTH-1:0] A,
    input  logic [BUSWIDTH-1:0] B,
    input  logic                load,
    input  logic                sel,
    output logic [BUSWIDTH-1:0] C_out
);

    localparam int c_NPROD = 7;

    logic [DATAWIDTH-1:0] w_a00, w_a01, w_a10, w_a11;
    logic [DATAWIDTH-1:0] w_b00, w_b01, w_b10, w_b11;
    logic [DATAWIDTH-1:0] w_t [c_NPROD];
    logic [DATAWIDTH-1:0] w_s [c_NPROD];
    logic [DATAWIDTH-1:0] w_m [c_NPROD];
    logic [DATAWIDTH-1:0] r_t [c_NPROD];
    logic [DATAWIDTH-1:0] r_s [c_NPROD];
    logic                 r_sel_q;
    logic [DATAWIDTH-1:0] w_c00, w_c01, w_c10, w_c11;
    logic [BUSWIDTH-1:0]  w_c_next;

    assign w_a00 = A[0*DATAWIDTH +: DATAWIDTH];
    assign w_a01 = A[1*DATAWIDTH +: DATAWIDTH];
    assign w_a10 = A[2*DATAWIDTH +: DATAWIDTH];
    assign w_a11 = A[3*DATAWIDTH +: DATAWIDTH];
    assign w_b00 = B[0*DATAWIDTH +: DATAWIDTH];
    assign w_b10 = B[2*DATAWIDTH +: DATAWIDTH];
    // Vector mode replicates column 0 of B into column 1 before forming sums.
    assign w_b01 = sel ? w_b00 : B[1*DATAWIDTH +: DATAWIDTH];
    assign w_b11 = sel ? w_b10 : B[3*DATAWIDTH +: DATAWIDTH];

    always_comb begin
        w_t[0] = sel ? '0 : (w_a00 + w_a11);
        w_t[1] = w_a10 + w_a11;
        w_t[2] = w_a00;
        w_t[3] = w_a11;
        w_t[4] = w_a00 + w_a01;
        w_t[5] = sel ? '0 : (w_a10 - w_a00);
        w_t[6] = sel ? '0 : (w_a01 - w_a11);
        w_s[0] = sel ? '0 : (w_b00 + w_b11);
        w_s[1] = w_b00;
        w_s[2] = w_b01 - w_b11;
        w_s[3] = w_b10 - w_b00;
        w_s[4] = w_b11;
        w_s[5] = sel ? '0 : (w_b00 + w_b01);
        w_s[6] = sel ? '0 : (w_b10 + w_b11);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NPROD; i++) begin
                r_t[i] <= '0;
                r_s[i] <= '0;
            end
            r_sel_q <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < c_NPROD; i++) begin
                r_t[i] <= w_t[i];
                r_s[i] <= w_s[i];
            end
            r_sel_q <= sel;
        end
    end

    // Truncated products: low DATAWIDTH bits are identical for signed/unsigned.
    for (genvar g = 0; g < c_NPROD; g++) begin : g_prod
        assign w_m[g] = r_t[g] * r_s[g];
    end

    assign w_c00 = w_m[0] + w_m[3] - w_m[4] + w_m[6];
    assign w_c01 = w_m[2] + w_m[4];
    assign w_c10 = w_m[1] + w_m[3];
    assign w_c11 = w_m[0] - w_m[1] + w_m[2] + w_m[5];

    always_comb begin
        w_c_next = {w_c11, w_c10, w_c01, w_c00};
        if (r_sel_q) begin
            w_c_next = {{DATAWIDTH{1'b0}}, w_c10, {DATAWIDTH{1'b0}}, w_c01};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            C_out <= '0;
        end else begin
            C_out <= w_c_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smm0.sv
`default_nettype none
// ============================================================================
// Module      : tb_smm0
// Description : Self-checking bench for smm0 against a plain matrix-product model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smm0;

    localparam int c_DW = 32;
    localparam int c_BW = c_DW * 4;

    logic            clk;
    logic            rst;
    logic [c_BW-1:0] A;
    logic [c_BW-1:0] B;
    logic            load;
    logic            sel;
    logic [c_BW-1:0] C_out;

    int total = 0;
    int bad   = 0;

    logic [c_BW-1:0] r_mdl_stage;
    logic [c_BW-1:0] r_mdl_out;

    smm0 dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .load  (load),
        .sel   (sel),
        .C_out (C_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [c_BW-1:0] mk(input int e00, input int e01, input int e10, input int e11);
        return {e11, e10, e01, e00};
    endfunction

    // Reference: ordinary row-by-column product, mod 2^32.
    function automatic logic [c_BW-1:0] ref_mul(input logic [c_BW-1:0] a, input logic [c_BW-1:0] b,
                                                input logic s);
        logic [c_DW-1:0] ea [2][2];
        logic [c_DW-1:0] eb [2][2];
        logic [c_DW-1:0] ec [2][2];
        logic [c_BW-1:0] res;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                ea[r][c] = a[(2*r+c)*c_DW +: c_DW];
                eb[r][c] = b[(2*r+c)*c_DW +: c_DW];
            end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                ec[r][c] = ea[r][0] * eb[0][c] + ea[r][1] * eb[1][c];
                if (s && c == 1) ec[r][c] = '0;
            end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                res[(2*r+c)*c_DW +: c_DW] = ec[r][c];
        return res;
    endfunction

    task automatic check(input string tag, input logic [c_BW-1:0] got, input logic [c_BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock, update the model with the inputs seen at that edge, then compare.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            r_mdl_out   = '0;
            r_mdl_stage = '0;
        end else begin
            r_mdl_out = r_mdl_stage;
            if (load) r_mdl_stage = ref_mul(A, B, sel);
        end
        #1;
        check("model", C_out, r_mdl_out);
    endtask

    task automatic run_one(input logic [c_BW-1:0] a, input logic [c_BW-1:0] b, input logic s,
                           input logic [c_BW-1:0] exp, input string tag);
        A = a; B = b; sel = s; load = 1'b1;
        step();
        load = 1'b0;
        step();
        check(tag, C_out, exp);
    endtask

    logic [c_BW-1:0] v_a2, v_b2, v_a3, v_b3, v_r2, v_r3;

    initial begin
        r_mdl_stage = '0;
        r_mdl_out   = '0;
        rst = 1'b1; load = 1'b0; sel = 1'b0; A = '0; B = '0;
        v_a2 = mk(1, 2, 3, 4);   v_b2 = mk(5, 6, 7, 8);   v_r2 = mk(19, 22, 43, 50);
        v_a3 = mk(-1, 0, 0, -1); v_b3 = mk(2, 3, 4, 5);   v_r3 = mk(-2, -3, -4, -5);

        step(); step();
        check("reset", C_out, '0);
        rst = 1'b0;
        repeat (3) step();
        check("idle", C_out, '0);

        run_one(v_a2, v_b2, 1'b0, v_r2, "mat_1234");
        run_one(v_a3, v_b3, 1'b0, v_r3, "mat_neg");
        run_one(v_a2, v_b2, 1'b1, mk(19, 0, 43, 0), "vec_mode");
        run_one(mk(32'h0001_0000, 0, 0, 0), mk(32'h0001_0000, 0, 0, 0), 1'b0, '0, "wrap");

        // Back-to-back loads stream one result per cycle.
        A = v_a2; B = v_b2; sel = 1'b0; load = 1'b1;
        step();
        A = v_a3; B = v_b3;
        step();
        check("stream0", C_out, v_r2);
        load = 1'b0;
        step();
        check("stream1", C_out, v_r3);

        // sel and inputs changing without load leave the result untouched.
        sel = 1'b1; A = v_a2; B = v_b2;
        repeat (2) step();
        check("sel_noload", C_out, v_r3);

        // Reset on the edge where the result would appear discards it.
        A = v_a2; B = v_b2; sel = 1'b0; load = 1'b1;
        step();
        load = 1'b0; rst = 1'b1;
        step();
        check("rst_mid", C_out, '0);
        rst = 1'b0;
        repeat (3) step();
        check("rst_after", C_out, '0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                A[k*c_DW +: c_DW] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40) - 20;
                B[k*c_DW +: c_DW] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40) - 20;
            end
            sel  = $urandom_range(0, 1);
            load = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
